lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Parametrised load/store unit placed between the datapath's data-memory signals and the data memory. It takes one load or store per request, validates the funct3 width and address alignment, and drives a ready-handshaked memory port with an aligned address and byte-lane enables. Load data is shifted and sign- or zero-extended before return. It supports 32- and 64-bit datapaths and ends stalled accesses with a bus-timeout fault.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- ADDR_W, 32, address width
- TIMEOUT, 256, maximum cycles waiting for i_mem_ready; 0 disables the watchdog
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  access request; sampled only when o_busy=0
- i_we  in  1  1=store, 0=load
- i_f3  in  3  RISC-V funct3 width/sign code
- i_addr  in  ADDR_W  byte address
- i_wdata  in  XLEN  store data, LSB-justified
- o_busy  out  1  unit is processing an access
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  XLEN  extended load result; valid with o_done, held until next o_done
- o_fault  out  2  fault code with o_done: 00 none, 01 misaligned, 10 illegal f3, 11 timeout
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes (low log2(XLEN/8) bits zero)
- o_mem_wdata  out  XLEN  store data replicated into the addressed lanes
- o_mem_be  out  XLEN/8  byte-lane enables (loads: lanes read)
- i_mem_ready  in  1  memory accepted/completed the access this cycle
- i_mem_rdata  in  XLEN  read data, valid when i_mem_ready=1

## Operation
- Access size comes from i_f3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- i_f3[2]=1 selects an unsigned load.
- Illegal codes:
  - f3=011 and f3=110 when XLEN=32.
  - f3=111 always.
  - Any store with i_f3[2]=1.
- Misaligned: the address is not a multiple of the access size. Checks run in priority order illegal f3, then misaligned.
- States:
  - IDLE: o_busy=0. On i_req, latch we/f3/addr/wdata. A faulting access goes to FAULT; otherwise go to REQ and clear the timeout counter.
  - REQ: o_mem_req=1 with all o_mem_* stable. On i_mem_ready, capture the extended load data (loads only) and go to DONE. Otherwise the counter increments. If TIMEOUT≠0 and the count reaches TIMEOUT-1 without ready, go to DONE with fault 11.
  - FAULT: o_done=1 and the fault code is driven. No memory access is made. Next state is IDLE.
  - DONE: o_done=1 and o_fault is driven. Next state is IDLE.
- Load data path: shift i_mem_rdata right by 8·offset, where offset = addr[log2(XLEN/8)-1:0]. Then sign- or zero-extend from bit 7, 15 or 31 to XLEN. A double load is passed through.
- Store path: o_mem_be is a run of size-many ones shifted left by offset. o_mem_wdata is i_wdata replicated to fill XLEN, so lane k carries byte (k mod size) of the store data.
- On a fault or timeout, o_rdata keeps its previous value.

## Timing
- Reset (async, immediate) gives: state IDLE, o_busy=0, o_done=0, o_fault=00, o_rdata=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, counter=0.
- Reset asserted mid-access drops o_mem_req in the same cycle and does not complete the access.
- i_req accepted at edge 0:
  - o_busy=1 and o_mem_req=1 from cycle 1.
  - If ready is seen at edge k (k≥1), o_done pulses in cycle k+1 and o_busy returns to 0 in cycle k+2.
  - Minimum load/store latency from request to o_done is 2 cycles.
- A faulting request pulses o_done in cycle 1, with o_mem_req never asserted.
- o_busy stays 1 through the o_done cycle. A new i_req is accepted at the earliest one cycle after o_done.
- i_mem_ready is ignored outside REQ. If ready and timeout coincide in the same cycle, ready wins and the fault is 00.
- Memory outputs are registered and change only when entering REQ or on reset.

## Test plan
- XLEN=32, LB addr 0x103, rdata 0x80FF_FF00, ready after 1 cycle -> o_mem_addr 0x100, be 1111, o_rdata 0xFFFF_FF80, o_fault 00, o_done at cycle 2.
- XLEN=32, SH addr 0x102, wdata 0x1234_ABCD -> be 1100, o_mem_wdata 0xABCD_ABCD, o_mem_we 1.
- XLEN=64, LWU addr 0x14, rdata 0x8765_4321_0000_0000 -> o_rdata 0x0000_0000_8765_4321. The same access with LW -> 0xFFFF_FFFF_8765_4321.
- Faults:
  - LW addr 0x101 -> o_fault 01 at cycle 1, no o_mem_req.
  - XLEN=32 LD (f3=011) -> o_fault 10.
  - SB with f3=100 -> o_fault 10.
- TIMEOUT=4, ready held low -> o_fault 11 after 4 REQ cycles, o_rdata unchanged.
- Ready in the last REQ cycle -> normal completion with fault 00.
- Assert i_rst_n=0 during REQ -> o_mem_req=0 immediately, o_busy=0, no o_done. After release, a new request completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit: validates funct3 width and alignment, drives a ready-handshaked
// memory port with aligned address and byte lanes, and extends returned load data.
module lsu_mem_port #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_f3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic [1:0]        o_fault,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_mem_ready,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB       = XLEN / 8;
  localparam int OFF_W    = $clog2(NB);
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        fault_reg, fault_next;
  logic [XLEN-1:0]   rdata_reg, rdata_next;
  logic              load_mem;

  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [XLEN-1:0]   mem_wdata_reg;
  logic [NB-1:0]     mem_be_reg;
  logic [2:0]        f3_reg;
  logic [OFF_W-1:0]  off_reg;

  // Request decode, evaluated on the incoming request while idle
  logic [1:0]        req_size;
  logic [OFF_W-1:0]  req_off;
  logic              req_illegal;
  logic              req_misaligned;
  logic [1:0]        req_fault;
  logic [4:0]        lane_lo;
  logic [4:0]        lane_hi;
  logic [NB-1:0]     be_next;
  logic [NB-1:0][7:0] wdata_rep;
  logic [ADDR_W-1:0] addr_aligned;

  assign req_size     = i_f3[1:0];
  assign req_off      = i_addr[OFF_W-1:0];
  assign addr_aligned = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign lane_lo      = 5'(req_off);
  assign lane_hi      = lane_lo + (5'd1 << req_size);

  always_comb begin
    req_illegal = (i_f3 == 3'b111) || (i_we && i_f3[2]);
    if (XLEN == 32 && (i_f3[1:0] == 2'b11 || i_f3 == 3'b110)) begin
      req_illegal = 1'b1;
    end
    case (req_size)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = i_addr[0];
      2'b10:   req_misaligned = (i_addr[1:0] != 2'b00);
      default: req_misaligned = (i_addr[2:0] != 3'b000);
    endcase
    if (req_illegal) begin
      req_fault = 2'b10;
    end else if (req_misaligned) begin
      req_fault = 2'b01;
    end else begin
      req_fault = 2'b00;
    end
  end

  // Loads read the whole aligned word; stores enable only the addressed lanes.
  // Lane k carries byte (k mod size) of the store data.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign be_next[gi] = !i_we || ((5'(gi) >= lane_lo) && (5'(gi) < lane_hi));
      assign wdata_rep[gi] = (req_size == 2'b00) ? i_wdata[7:0] :
                             (req_size == 2'b01) ? i_wdata[8*(gi%2) +: 8] :
                             (req_size == 2'b10) ? i_wdata[8*(gi%4) +: 8] :
                                                   i_wdata[8*(gi%8) +: 8];
    end
  endgenerate

  // Load return: shift the addressed bytes down, then mask and extend
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_keep;
  logic            ld_sbit;
  logic [XLEN-1:0] ld_ext;

  assign ld_sh = i_mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (f3_reg[1:0])
      2'b00: begin
        ld_keep = XLEN'(8'hFF);
        ld_sbit = ld_sh[7];
      end
      2'b01: begin
        ld_keep = XLEN'(16'hFFFF);
        ld_sbit = ld_sh[15];
      end
      2'b10: begin
        ld_keep = XLEN'(32'hFFFF_FFFF);
        ld_sbit = ld_sh[31];
      end
      default: begin
        ld_keep = '1;
        ld_sbit = 1'b0;
      end
    endcase
    ld_ext = (ld_sh & ld_keep) | ((ld_sbit && !f3_reg[2]) ? ~ld_keep : '0);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fault_next = fault_reg;
    rdata_next = rdata_reg;
    load_mem   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_req) begin
          if (req_fault != 2'b00) begin
            state_next = S_FAULT;
            fault_next = req_fault;
          end else begin
            state_next = S_REQ;
            cnt_next   = '0;
            load_mem   = 1'b1;
          end
        end
      end
      S_REQ: begin
        // Ready takes precedence over an expiring watchdog in the same cycle
        if (i_mem_ready) begin
          state_next = S_DONE;
          fault_next = 2'b00;
          if (!mem_we_reg) begin
            rdata_next = ld_ext;
          end
        end else if (TIMEOUT != 0 && cnt_reg == CNT_W'(CNT_LAST)) begin
          state_next = S_DONE;
          fault_next = 2'b11;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_FAULT, S_DONE: begin
        state_next = S_IDLE;
        fault_next = 2'b00;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      fault_reg     <= 2'b00;
      rdata_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      f3_reg        <= 3'b000;
      off_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      fault_reg   <= fault_next;
      rdata_reg   <= rdata_next;
      mem_req_reg <= (state_next == S_REQ);
      if (load_mem) begin
        mem_we_reg    <= i_we;
        mem_addr_reg  <= addr_aligned;
        mem_wdata_reg <= wdata_rep;
        mem_be_reg    <= be_next;
        f3_reg        <= i_f3;
        off_reg       <= req_off;
      end
    end
  end

  assign o_busy      = (state_reg != S_IDLE);
  assign o_done      = (state_reg == S_DONE) || (state_reg == S_FAULT);
  assign o_fault     = fault_reg;
  assign o_rdata     = rdata_reg;
  assign o_mem_req   = mem_req_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_be    = mem_be_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: a 32-bit and a 64-bit instance driven by directed and
// random accesses, checked every cycle against a transaction-level model.
module tb_lsu_mem_port;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req[2], we[2], mready[2];
  logic [2:0]  f3[2];
  logic [31:0] addr[2];
  logic [63:0] wdata[2], mrdata[2];

  logic        busy_o[2], done_o[2], mreq_o[2], mwe_o[2];
  logic [1:0]  fault_o[2];
  logic [31:0] maddr_o[2];
  logic [63:0] rdata_o[2], mwdata_o[2];
  logic [7:0]  be_o[2];

  logic [31:0] rdata32, mwdata32;
  logic [3:0]  be32;
  logic [63:0] rdata64, mwdata64;
  logic [7:0]  be64;

  assign rdata_o[0]  = {32'd0, rdata32};
  assign mwdata_o[0] = {32'd0, mwdata32};
  assign be_o[0]     = {4'd0, be32};
  assign rdata_o[1]  = rdata64;
  assign mwdata_o[1] = mwdata64;
  assign be_o[1]     = be64;

  lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_we(we[0]), .i_f3(f3[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0][31:0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
    .o_rdata(rdata32), .o_fault(fault_o[0]), .o_mem_req(mreq_o[0]), .o_mem_we(mwe_o[0]),
    .o_mem_addr(maddr_o[0]), .o_mem_wdata(mwdata32), .o_mem_be(be32),
    .i_mem_ready(mready[0]), .i_mem_rdata(mrdata[0][31:0])
  );

  lsu_mem_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_we(we[1]), .i_f3(f3[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
    .o_rdata(rdata64), .o_fault(fault_o[1]), .o_mem_req(mreq_o[1]), .o_mem_we(mwe_o[1]),
    .o_mem_addr(maddr_o[1]), .o_mem_wdata(mwdata64), .o_mem_be(be64),
    .i_mem_ready(mready[1]), .i_mem_rdata(mrdata[1])
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations, set by the driver, consumed by the compare process
  logic        exp_busy[2], exp_done[2], exp_req[2], exp_we[2];
  logic [1:0]  exp_fault[2];
  logic [63:0] exp_rdata[2], exp_wdata[2];
  logic [31:0] exp_addr[2];
  logic [7:0]  exp_be[2];
  logic [1:0]  obs_fault[2];

  task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, act, req_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_fault(input int xl, input logic w, input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    if (f == 3'b111 || (w && f[2]) || (xl == 32 && (sz == 8 || f == 3'b110))) return 2'b10;
    if ((a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_addr(input int xl, input logic [31:0] a);
    return a - (a % (xl / 8));
  endfunction

  function automatic logic [7:0] m_be(input int xl, input logic w, input logic [2:0] f, input logic [31:0] a);
    int nb, sz;
    nb = xl / 8;
    sz = 1 << f[1:0];
    if (!w) return 8'((1 << nb) - 1);
    return 8'(((1 << sz) - 1) << (a % nb));
  endfunction

  function automatic logic [63:0] m_wdata(input int xl, input logic [2:0] f, input logic [63:0] wd);
    logic [63:0] v;
    int sz;
    v = '0;
    sz = 1 << f[1:0];
    for (int k = 0; k < xl / 8; k++) v[8*k +: 8] = wd[8*(k % sz) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input int xl, input logic [2:0] f, input logic [31:0] a, input logic [63:0] rd);
    logic [63:0] v, m;
    int sz, off;
    sz  = 1 << f[1:0];
    off = a % (xl / 8);
    if (xl == 32) rd = rd & 64'hFFFF_FFFF;
    v = rd >> (8 * off);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (!f[2] && v[8*sz-1]) v = v | ~m;
    end
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        check("busy", d, 64'(busy_o[d]), 64'(exp_busy[d]));
        check("done", d, 64'(done_o[d]), 64'(exp_done[d]));
        check("mem_req", d, 64'(mreq_o[d]), 64'(exp_req[d]));
        check("rdata", d, rdata_o[d], exp_rdata[d]);
        if (exp_done[d]) check("fault", d, 64'(fault_o[d]), 64'(exp_fault[d]));
        if (exp_req[d]) begin
          check("mem_addr", d, 64'(maddr_o[d]), 64'(exp_addr[d]));
          check("mem_we", d, 64'(mwe_o[d]), 64'(exp_we[d]));
          check("mem_be", d, 64'(be_o[d]), 64'(exp_be[d]));
          if (exp_we[d]) check("mem_wdata", d, mwdata_o[d], exp_wdata[d]);
        end
      end
    end
  end

  task automatic set_idle(input int d);
    exp_busy[d] = 1'b0;
    exp_done[d] = 1'b0;
    exp_req[d]  = 1'b0;
  endtask

  // One access; ready is raised in REQ cycle k (k > TMO means it never comes in time).
  // Called just after a rising edge with the unit idle; returns in its next idle cycle.
  task automatic txn(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [63:0] wd, input int k, input logic fix, input logic [63:0] rd_fix);
    int          xl, n;
    logic [1:0]  flt;
    logic [63:0] rd_hit;
    xl     = (d == 0) ? 32 : 64;
    flt    = m_fault(xl, w, f, a);
    rd_hit = '0;
    req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wdata[d] = wd;
    mready[d] = 1'($urandom_range(0, 1));
    mrdata[d] = {$urandom, $urandom};
    set_idle(d);
    @(posedge clk); #1;
    // scramble request inputs: the unit must work from its latched copy
    req[d] = 1'b0; we[d] = 1'($urandom_range(0, 1)); f3[d] = 3'($urandom_range(0, 7));
    addr[d] = $urandom; wdata[d] = {$urandom, $urandom};
    if (flt != 2'b00) begin
      mready[d]    = 1'($urandom_range(0, 1));
      exp_busy[d]  = 1'b1; exp_done[d] = 1'b1; exp_req[d] = 1'b0;
      exp_fault[d] = flt;
      obs_fault[d] = fault_o[d];
      @(posedge clk); #1;
    end else begin
      n = (k <= TMO) ? k : TMO;
      exp_addr[d]  = m_addr(xl, a);
      exp_be[d]    = m_be(xl, w, f, a);
      exp_we[d]    = w;
      exp_wdata[d] = m_wdata(xl, f, wd);
      for (int c = 1; c <= n; c++) begin
        mready[d] = (c == k);
        mrdata[d] = (fix && c == k) ? rd_fix : {$urandom, $urandom};
        if (c == k) rd_hit = mrdata[d];
        exp_busy[d] = 1'b1; exp_done[d] = 1'b0; exp_req[d] = 1'b1;
        @(posedge clk); #1;
      end
      mready[d]    = 1'($urandom_range(0, 1));
      mrdata[d]    = {$urandom, $urandom};
      exp_busy[d]  = 1'b1; exp_done[d] = 1'b1; exp_req[d] = 1'b0;
      exp_fault[d] = (k > TMO) ? 2'b11 : 2'b00;
      if (k <= TMO && !w) exp_rdata[d] = m_load(xl, f, a, rd_hit);
      obs_fault[d] = fault_o[d];
      @(posedge clk); #1;
    end
    mready[d] = 1'b0;
    set_idle(d);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    int          sz;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'b000; addr[d] = '0; wdata[d] = '0;
      mready[d] = 1'b0; mrdata[d] = '0;
      exp_rdata[d] = '0; exp_wdata[d] = '0; exp_addr[d] = '0; exp_be[d] = '0;
      exp_we[d] = 1'b0; exp_fault[d] = 2'b00; obs_fault[d] = 2'b00;
      set_idle(d);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", d, 64'(busy_o[d]), 64'd0);
      check("rst_done", d, 64'(done_o[d]), 64'd0);
      check("rst_fault", d, 64'(fault_o[d]), 64'd0);
      check("rst_rdata", d, rdata_o[d], 64'd0);
      check("rst_mem_req", d, 64'(mreq_o[d]), 64'd0);
      check("rst_mem_we", d, 64'(mwe_o[d]), 64'd0);
      check("rst_mem_addr", d, 64'(maddr_o[d]), 64'd0);
      check("rst_mem_wdata", d, mwdata_o[d], 64'd0);
      check("rst_mem_be", d, 64'(be_o[d]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed, XLEN=32 ----
    txn(0, 1'b0, 3'b000, 32'h103, 64'h0, 1, 1'b1, 64'h0000_0000_80FF_FF00);
    check("lb_rdata", 0, rdata_o[0], 64'hFFFF_FF80);
    check("lb_addr", 0, 64'(maddr_o[0]), 64'h100);
    check("lb_be", 0, 64'(be_o[0]), 64'h0F);
    check("lb_fault", 0, 64'(obs_fault[0]), 64'd0);
    txn(0, 1'b1, 3'b001, 32'h102, 64'h1234_ABCD, 2, 1'b0, 64'h0);
    check("sh_be", 0, 64'(be_o[0]), 64'h0C);
    check("sh_wdata", 0, mwdata_o[0], 64'hABCD_ABCD);
    check("sh_we", 0, 64'(mwe_o[0]), 64'd1);
    txn(0, 1'b0, 3'b010, 32'h101, 64'h0, 1, 1'b0, 64'h0);
    check("lw_misaligned", 0, 64'(obs_fault[0]), 64'd1);
    txn(0, 1'b0, 3'b011, 32'h100, 64'h0, 1, 1'b0, 64'h0);
    check("ld32_illegal", 0, 64'(obs_fault[0]), 64'd2);
    txn(0, 1'b1, 3'b100, 32'h100, 64'h55, 1, 1'b0, 64'h0);
    check("sbu_illegal", 0, 64'(obs_fault[0]), 64'd2);
    txn(0, 1'b0, 3'b010, 32'h100, 64'h0, TMO + 2, 1'b0, 64'h0);
    check("timeout_fault", 0, 64'(obs_fault[0]), 64'd3);
    check("timeout_rdata", 0, rdata_o[0], 64'hFFFF_FF80);
    txn(0, 1'b0, 3'b010, 32'h104, 64'h0, TMO, 1'b1, 64'h0000_0000_1122_3344);
    check("lastcyc_fault", 0, 64'(obs_fault[0]), 64'd0);
    check("lastcyc_rdata", 0, rdata_o[0], 64'h1122_3344);

    // ---- directed, XLEN=64 ----
    txn(1, 1'b0, 3'b110, 32'h14, 64'h0, 1, 1'b1, 64'h8765_4321_0000_0000);
    check("lwu64_rdata", 1, rdata_o[1], 64'h0000_0000_8765_4321);
    txn(1, 1'b0, 3'b010, 32'h14, 64'h0, 3, 1'b1, 64'h8765_4321_0000_0000);
    check("lw64_rdata", 1, rdata_o[1], 64'hFFFF_FFFF_8765_4321);
    txn(1, 1'b1, 3'b000, 32'h25, 64'h0000_0000_0000_00A5, 1, 1'b0, 64'h0);
    check("sb64_be", 1, 64'(be_o[1]), 64'h20);
    check("sb64_wdata", 1, mwdata_o[1], 64'hA5A5_A5A5_A5A5_A5A5);

    // ---- random ----
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        rf = 3'($urandom_range(0, 7));
        sz = 1 << rf[1:0];
        ra = $urandom & 32'h0000_0FFF;
        if ($urandom_range(0, 3) != 0) ra = ra & ~32'(sz - 1);
        txn(d, 1'($urandom_range(0, 1)), rf, ra, {$urandom, $urandom},
            $urandom_range(1, TMO + 2), 1'b0, 64'h0);
      end
    end

    // ---- reset during REQ ----
    req[1] = 1'b1; we[1] = 1'b0; f3[1] = 3'b010; addr[1] = 32'h20;
    @(posedge clk); #1;
    req[1] = 1'b0; mready[1] = 1'b0;
    exp_busy[1] = 1'b1; exp_req[1] = 1'b1; exp_done[1] = 1'b0;
    exp_addr[1] = 32'h20; exp_be[1] = 8'hFF; exp_we[1] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_req", 1, 64'(mreq_o[1]), 64'd0);
    check("rstmid_busy", 1, 64'(busy_o[1]), 64'd0);
    check("rstmid_done", 1, 64'(done_o[1]), 64'd0);
    check("rstmid_rdata", 1, rdata_o[1], 64'd0);
    for (int d = 0; d < 2; d++) begin
      set_idle(d);
      exp_rdata[d] = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    txn(1, 1'b0, 3'b011, 32'h40, 64'h0, 2, 1'b1, 64'h0123_4567_89AB_CDEF);
    check("post_rst_rdata", 1, rdata_o[1], 64'h0123_4567_89AB_CDEF);
    check("post_rst_fault", 1, 64'(obs_fault[1]), 64'd0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
